// File: rtl/vixen_mem_line_ctrl_pkg.sv
// rtl/vixen_mem_line_ctrl_pkg.sv - shared widths, state and beat-index types for the line controller
// Contents: LINE_W/BEAT_W/BEATS/OFFSET_BITS, mem_ctrl_state_t, beat_idx_t.
package vixen_mem_pkg;

  localparam int LINE_W      = 512;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    ACK   = 3'd4
  } mem_ctrl_state_t;

  typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

endpackage

// File: rtl/vixen_mem_line_ctrl_if.sv
// rtl/vixen_mem_line_ctrl_if.sv - downstream command / write-beat / read-beat bus
// Channels: cmd (valid/ready, addr, we), wbeat (valid/ready, data), rbeat (valid/ready, data).
// master = line controller, slave = memory side.
interface vixen_mem_line_ctrl_if;
  import vixen_mem_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [63:0]       cmd_addr;
  logic              cmd_we;
  logic              wbeat_valid;
  logic              wbeat_ready;
  logic [BEAT_W-1:0] wbeat_data;
  logic              rbeat_valid;
  logic              rbeat_ready;
  logic [BEAT_W-1:0] rbeat_data;

  modport master (
    output cmd_valid, cmd_addr, cmd_we, wbeat_valid, wbeat_data, rbeat_ready,
    input  cmd_ready, wbeat_ready, rbeat_valid, rbeat_data
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_we, wbeat_valid, wbeat_data, rbeat_ready,
    output cmd_ready, wbeat_ready, rbeat_valid, rbeat_data
  );

endinterface

// File: rtl/vixen_mem_line_ctrl_watchdog.sv
// rtl/vixen_mem_line_ctrl_watchdog.sv - stall watchdog counter for the line controller
// Ports: clk, rst (async, active-high); en = count while set, clr = restart count,
// expired = LIMIT consecutive enabled cycles without clr (combinational, this cycle).
module vixen_mem_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  // The expiring cycle is itself the LIMIT-th stalled cycle, so the
  // owner can leave its waiting state on the very next edge.
  assign expired = en && !clr && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || clr) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/vixen_mem_line_ctrl.sv
// rtl/vixen_mem_line_ctrl.sv - splits L3 line requests into a command plus 64-bit beats
// Optional macro VIXEN_MEM_TIMEOUT_EN: watchdog (TIMEOUT_CYCLES) ends a stalled
// transfer with mem_ack + mem_err; reads that time out return all-ones.
// Ports: clk, rst (async, active-high); L3 side mem_req/mem_addr/mem_we/mem_wdata in,
// mem_ready/mem_ack/mem_rdata/mem_err out; bus = downstream channels (master).
module vixen_mem_line_ctrl
  import vixen_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic [63:0]       mem_addr,
  input  logic              mem_we,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic              mem_ack,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_err,
  vixen_mem_line_ctrl_if.master bus
);

  localparam logic [63:0] ADDR_MASK = ~((64'd1 << OFFSET_BITS) - 64'd1);

  mem_ctrl_state_t   state_q, state_d;
  beat_idx_t         cnt_q;
  logic [LINE_W-1:0] buf_q;
  logic [LINE_W-1:0] rdata_q;
  logic [63:0]       addr_q;
  logic              we_q;
  logic              started_q;

  logic cmd_valid, wbeat_valid, rbeat_ready;
  logic accept, cmd_hs, wbeat_hs, rbeat_hs, last_beat, timeout;

  assign accept    = mem_ready && mem_req;
  assign cmd_hs    = cmd_valid && bus.cmd_ready;
  assign wbeat_hs  = wbeat_valid && bus.wbeat_ready;
  assign rbeat_hs  = rbeat_ready && bus.rbeat_valid;
  assign last_beat = (cnt_q == beat_idx_t'(BEATS - 1));

`ifdef VIXEN_MEM_TIMEOUT_EN
  logic err_q;

  vixen_mem_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q inside {CMD, WDATA, RDATA}),
    .clr     (cmd_hs || wbeat_hs || rbeat_hs),
    .expired (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err = mem_ack && err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_ready   = 1'b0;
    mem_ack     = 1'b0;
    cmd_valid   = 1'b0;
    wbeat_valid = 1'b0;
    rbeat_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // started_q keeps mem_ready low for the first cycle out of reset.
        mem_ready = started_q;
        if (started_q && mem_req) state_d = CMD;
      end
      CMD: begin
        cmd_valid = 1'b1;
        if (bus.cmd_ready) state_d = we_q ? WDATA : RDATA;
      end
      WDATA: begin
        wbeat_valid = 1'b1;
        if (bus.wbeat_ready && last_beat) state_d = ACK;
      end
      RDATA: begin
        rbeat_ready = 1'b1;
        if (bus.rbeat_valid && last_beat) state_d = ACK;
      end
      ACK: begin
        mem_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The watchdog only fires on a cycle with no handshake, so it never
    // competes with a beat being taken.
    if (timeout) state_d = ACK;
  end

  assign bus.cmd_valid   = cmd_valid;
  assign bus.cmd_addr    = addr_q;
  assign bus.cmd_we      = we_q;
  assign bus.wbeat_valid = wbeat_valid;
  assign bus.wbeat_data  = wbeat_valid ? buf_q[int'(cnt_q) * BEAT_W +: BEAT_W] : '0;
  assign bus.rbeat_ready = rbeat_ready;

  // The assembled line is visible in the ack cycle itself; rdata_q takes
  // it over from the next cycle so writes leave the last read untouched.
  assign mem_rdata = (mem_ack && !we_q) ? buf_q : rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      cnt_q     <= '0;
      buf_q     <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= mem_addr & ADDR_MASK;
            we_q   <= mem_we;
            buf_q  <= mem_wdata;
          end
        end
        CMD: begin
          if (cmd_hs) cnt_q <= '0;
        end
        WDATA: begin
          if (wbeat_hs) cnt_q <= cnt_q + 1'b1;
        end
        RDATA: begin
          if (rbeat_hs) begin
            buf_q[int'(cnt_q) * BEAT_W +: BEAT_W] <= bus.rbeat_data;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACK: begin
          if (!we_q) rdata_q <= buf_q;
        end
        default: ;
      endcase
      if (timeout && !we_q) buf_q <= '1;
    end
  end

endmodule

// File: tb/tb_vixen_mem_line_ctrl.sv
// tb/tb_vixen_mem_line_ctrl.sv - randomized self-checking bench for vixen_mem_line_ctrl
module tb_vixen_mem_line_ctrl;
  import vixen_mem_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic         mem_we;
  logic [511:0] mem_wdata;
  logic         mem_ready, mem_ack, mem_err;
  logic [511:0] mem_rdata;

  vixen_mem_line_ctrl_if bus();

  vixen_mem_line_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observations gathered by the downstream/L3 driver for one scenario.
  logic [63:0]  rwords[16];
  logic [63:0]  wseen[16];
  int           wcnt, rcnt, hold_viol;
  int           cmd_k[$];
  logic [63:0]  cmd_a[$];
  logic         cmd_w[$];
  int           ack_k[$];
  logic [511:0] ack_d[$];
  logic         ack_e[$];
  bit           drv_to;
  logic         ready_after_ack;
  logic [5:0]   abort_snap;
  logic [511:0] abort_rdata;
  logic [511:0] last_read;

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [511:0] words_line(input int base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[64*i +: 64] = rwords[base + i];
    return l;
  endfunction

  // k counts cycles after the request cycle T (k=0); outputs sampled at negedge.
  task automatic run_txn(input logic we, input logic [63:0] addr, input logic [511:0] wdata,
                         input int cmd_stall, input int mode, input int hold_cycles,
                         input int n_acks, input bit feed, input int abort_beats, input int max_k);
    bit pcv, pchs, pwv, pwhs, prv, prhs, cr, wr, rv;
    logic [63:0] pca, pwd;
    logic pcw;
    int cstall, done_k;
    cmd_k.delete(); cmd_a.delete(); cmd_w.delete();
    ack_k.delete(); ack_d.delete(); ack_e.delete();
    wcnt = 0; rcnt = 0; hold_viol = 0; drv_to = 0; ready_after_ack = 1'bx;
    pcv = 0; pchs = 0; pwv = 0; pwhs = 0; prv = 0; prhs = 0;
    pca = '0; pwd = '0; pcw = 0; cstall = 0; done_k = -1;
    @(negedge clk);
    mem_req = 1'b1; mem_addr = addr; mem_we = we; mem_wdata = wdata;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (k >= hold_cycles) mem_req = 1'b0;
      if (abort_beats >= 0 && rcnt == abort_beats) begin
        #2 rst = 1'b1;
        #1;
        abort_snap  = {bus.cmd_valid, bus.wbeat_valid, bus.rbeat_ready, mem_ack, mem_ready, mem_err};
        abort_rdata = mem_rdata;
        done_k = k;
        break;
      end
      if (bus.cmd_valid) begin
        if (!pcv || pchs) begin
          cmd_k.push_back(k); cmd_a.push_back(bus.cmd_addr); cmd_w.push_back(bus.cmd_we);
          cstall = 0;
        end else if (bus.cmd_addr !== pca || bus.cmd_we !== pcw) hold_viol++;
      end else if (pcv && !pchs) hold_viol++;
      cr = bus.cmd_valid && (cstall >= cmd_stall);
      if (bus.cmd_valid) cstall++;
      bus.cmd_ready = cr;
      pchs = bus.cmd_valid && cr; pcv = bus.cmd_valid; pca = bus.cmd_addr; pcw = bus.cmd_we;

      if (bus.wbeat_valid) begin
        if (pwv && !pwhs && bus.wbeat_data !== pwd) hold_viol++;
      end else if (pwv && !pwhs) hold_viol++;
      case (mode)
        0:       wr = 1'b1;
        1:       wr = (k % 2 == 1);
        default: wr = 1'($urandom_range(0, 1));
      endcase
      bus.wbeat_ready = wr;
      if (bus.wbeat_valid && wr) begin
        if (wcnt < 16) wseen[wcnt] = bus.wbeat_data;
        wcnt++;
      end
      pwhs = bus.wbeat_valid && wr; pwv = bus.wbeat_valid; pwd = bus.wbeat_data;

      if (prv && !prhs) rv = 1'b1;
      else case (mode)
        0:       rv = 1'b1;
        1:       rv = (k % 2 == 0);
        default: rv = 1'($urandom_range(0, 1));
      endcase
      rv = rv && feed && (rcnt < 16);
      bus.rbeat_valid = rv;
      bus.rbeat_data  = rv ? rwords[rcnt] : 64'hDEAD_BEEF_0BAD_F00D;
      prhs = rv && bus.rbeat_ready;
      if (prhs) rcnt++;
      prv = rv;

      if (ack_k.size() > 0 && k == ack_k[0] + 1) ready_after_ack = mem_ready;
      if (mem_ack) begin
        ack_k.push_back(k); ack_d.push_back(mem_rdata); ack_e.push_back(mem_err);
        if (ack_k.size() == n_acks) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    if (done_k < 0) drv_to = 1;
    mem_req = 1'b0;
    bus.cmd_ready = 1'b0; bus.wbeat_ready = 1'b0; bus.rbeat_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({mem_ready, mem_ack, mem_err, bus.cmd_valid, bus.cmd_we, bus.wbeat_valid, bus.rbeat_ready} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_strobes got=%b want=0000000",
               {mem_ready, mem_ack, mem_err, bus.cmd_valid, bus.cmd_we, bus.wbeat_valid, bus.rbeat_ready});
    end
    vectors++;
    if (bus.cmd_addr !== 64'h0 || bus.wbeat_data !== 64'h0 || mem_rdata !== 512'h0) begin
      miscompares++;
      $display("FAIL reset_data cmd_addr=%h wbeat=%h rdata_lo=%h want all 0", bus.cmd_addr, bus.wbeat_data, mem_rdata[63:0]);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge got=%b want=0", mem_ready); end
    @(negedge clk);
    vectors++;
    if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset got=%b want=1", mem_ready); end
  endtask

  task automatic test_read();
    logic [511:0] exp;
    for (int i = 0; i < 16; i++) rwords[i] = 64'(i);
    exp = words_line(0);
    run_txn(1'b0, 64'h1234, rand_line(), 0, 0, 1, 1, 1'b1, -1, 60);
    vectors++;
    if (cmd_k.size() != 1 || cmd_k[0] != 1) begin
      miscompares++; $display("FAIL read_cmd_cycle got n=%0d k=%0d want n=1 k=1", cmd_k.size(), cmd_k.size() ? cmd_k[0] : -1);
    end
    vectors++;
    if (cmd_a.size() == 0 || cmd_a[0] !== 64'h1200 || cmd_w[0] !== 1'b0) begin
      miscompares++; $display("FAIL read_cmd_fields addr=%h we=%b want 1200/0", cmd_a.size() ? cmd_a[0] : 64'hx, cmd_w.size() ? cmd_w[0] : 1'bx);
    end
    vectors++;
    if (ack_k.size() != 1 || ack_k[0] != 10) begin
      miscompares++; $display("FAIL read_ack_cycle got n=%0d k=%0d want n=1 k=10", ack_k.size(), ack_k.size() ? ack_k[0] : -1);
    end
    vectors++;
    if (ack_d.size() == 0 || ack_d[0] !== exp || ack_e[0] !== 1'b0) begin
      miscompares++; $display("FAIL read_line got_w7=%h want_w7=%h", ack_d.size() ? ack_d[0][511:448] : 64'hx, exp[511:448]);
    end
    vectors++;
    if (ready_after_ack !== 1'b1) begin miscompares++; $display("FAIL read_ready_T11 got=%b want=1", ready_after_ack); end
    vectors++;
    if (mem_rdata !== exp) begin miscompares++; $display("FAIL read_rdata_held got_w0=%h want_w0=%h", mem_rdata[63:0], exp[63:0]); end
    last_read = exp;
  endtask

  task automatic test_write_stall();
    logic [511:0] wd;
    for (int i = 0; i < 8; i++) wd[64*i +: 64] = 64'hA0 + 64'(i);
    run_txn(1'b1, 64'h0000_0000_0000_8040, wd, 3, 1, 1, 1, 1'b0, -1, 100);
    vectors++;
    if (wcnt != 8) begin miscompares++; $display("FAIL write_beat_count got=%0d want=8", wcnt); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (wseen[i] !== 64'hA0 + 64'(i)) begin
        miscompares++; $display("FAIL write_beat%0d got=%h want=%h", i, wseen[i], 64'hA0 + 64'(i));
      end
    end
    vectors++;
    if (hold_viol != 0) begin miscompares++; $display("FAIL write_hold_stable got=%0d violations want=0", hold_viol); end
    vectors++;
    if (ack_k.size() != 1 || ack_e[0] !== 1'b0) begin miscompares++; $display("FAIL write_ack_count got=%0d want=1", ack_k.size()); end
    vectors++;
    if (cmd_w.size() != 1 || cmd_w[0] !== 1'b1 || cmd_a[0] !== 64'h8040) begin
      miscompares++; $display("FAIL write_cmd_fields n=%0d want one write cmd at 8040", cmd_w.size());
    end
    vectors++;
    if (mem_rdata !== last_read) begin miscompares++; $display("FAIL write_keeps_rdata got_w0=%h want_w0=%h", mem_rdata[63:0], last_read[63:0]); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    for (int i = 0; i < 16; i++) rwords[i] = {$urandom, $urandom};
    a = {$urandom, $urandom};
    run_txn(1'b0, a, '0, 0, 0, 12, 2, 1'b1, -1, 80);
    vectors++;
    if (cmd_k.size() != 2 || cmd_k[0] != 1 || cmd_k[1] != 12) begin
      miscompares++; $display("FAIL b2b_cmd_cycles got n=%0d second=%0d want n=2 second=12", cmd_k.size(), cmd_k.size() > 1 ? cmd_k[1] : -1);
    end
    vectors++;
    if (ack_k.size() != 2 || ack_k[0] != 10 || ack_k[1] != 21) begin
      miscompares++; $display("FAIL b2b_acks got n=%0d want n=2 at 10,21", ack_k.size());
    end
    vectors++;
    if (ack_d.size() != 2 || ack_d[0] !== words_line(0) || ack_d[1] !== words_line(8)) begin
      miscompares++; $display("FAIL b2b_lines got n=%0d or wrong data want two lines", ack_d.size());
    end
    vectors++;
    if (cmd_a.size() != 2 || cmd_a[1] !== (a & ~64'd63)) begin
      miscompares++; $display("FAIL b2b_addr got=%h want=%h", cmd_a.size() > 1 ? cmd_a[1] : 64'hx, a & ~64'd63);
    end
    last_read = words_line(8);
  endtask

  task automatic test_reset_abort();
    logic [511:0] exp;
    for (int i = 0; i < 16; i++) rwords[i] = {$urandom, $urandom};
    run_txn(1'b0, 64'h40, '0, 0, 0, 1, 1, 1'b1, 4, 60);
    vectors++;
    if (abort_snap !== 6'b0 || abort_rdata !== 512'h0) begin
      miscompares++; $display("FAIL abort_outputs got=%b rdata_lo=%h want 000000/0", abort_snap, abort_rdata[63:0]);
    end
    vectors++;
    if (ack_k.size() != 0) begin miscompares++; $display("FAIL abort_no_ack got=%0d acks want=0", ack_k.size()); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_rdata !== 512'h0 || mem_ready !== 1'b1) begin
      miscompares++; $display("FAIL abort_recover rdata_lo=%h ready=%b want 0/1", mem_rdata[63:0], mem_ready);
    end
    for (int i = 0; i < 16; i++) rwords[i] = {$urandom, $urandom};
    exp = words_line(0);
    run_txn(1'b0, 64'h7fc0, '0, 0, 0, 1, 1, 1'b1, -1, 60);
    vectors++;
    if (ack_k.size() != 1 || ack_k[0] != 10 || ack_d[0] !== exp) begin
      miscompares++; $display("FAIL abort_fresh_read n=%0d k=%0d want one ack at 10 with line", ack_k.size(), ack_k.size() ? ack_k[0] : -1);
    end
    last_read = exp;
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic we;
      logic [63:0] a;
      logic [511:0] wd, exp;
      we = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      wd = rand_line();
      for (int i = 0; i < 16; i++) rwords[i] = {$urandom, $urandom};
      exp = we ? last_read : words_line(0);
      run_txn(we, a, wd, $urandom_range(0, 3), 2, 1, 1, 1'b1, -1, 300);
      vectors++;
      if (drv_to || ack_k.size() != 1 || ack_e[0] !== 1'b0) begin
        miscompares++; $display("FAIL rand%0d_ack timeout=%0d acks=%0d want one clean ack", t, drv_to, ack_k.size());
      end
      vectors++;
      if (cmd_a.size() != 1 || cmd_a[0] !== (a & ~64'd63) || cmd_w[0] !== we) begin
        miscompares++; $display("FAIL rand%0d_cmd addr=%h want=%h", t, cmd_a.size() ? cmd_a[0] : 64'hx, a & ~64'd63);
      end
      vectors++;
      if (hold_viol != 0) begin miscompares++; $display("FAIL rand%0d_hold got=%0d want=0", t, hold_viol); end
      vectors++;
      if (ack_d.size() == 0 || ack_d[0] !== exp) begin
        miscompares++; $display("FAIL rand%0d_rdata got_w0=%h want_w0=%h", t, ack_d.size() ? ack_d[0][63:0] : 64'hx, exp[63:0]);
      end
      if (we) begin
        vectors++;
        if (wcnt != 8 || words_eq_w(wd) == 0) begin
          miscompares++; $display("FAIL rand%0d_wbeats count=%0d want 8 beats of the request line", t, wcnt);
        end
      end
      if (!we) last_read = exp;
    end
  endtask

  function automatic int words_eq_w(input logic [511:0] wd);
    for (int i = 0; i < 8; i++) if (wseen[i] !== wd[64*i +: 64]) return 0;
    return 1;
  endfunction

  task automatic test_timeout();
`ifdef VIXEN_MEM_TIMEOUT_EN
    run_txn(1'b1, 64'h100, rand_line(), 1000, 0, 1, 1, 1'b0, -1, 60);
    vectors++;
    if (ack_k.size() != 1 || ack_k[0] != 17 || ack_e[0] !== 1'b1) begin
      miscompares++; $display("FAIL wr_timeout n=%0d k=%0d want one err ack at 17", ack_k.size(), ack_k.size() ? ack_k[0] : -1);
    end
    vectors++;
    if (ack_d.size() == 0 || ack_d[0] !== last_read) begin miscompares++; $display("FAIL wr_timeout_rdata changed want unchanged"); end
    run_txn(1'b0, 64'h200, '0, 0, 0, 1, 1, 1'b0, -1, 60);
    vectors++;
    if (ack_k.size() != 1 || ack_k[0] != 18 || ack_e[0] !== 1'b1) begin
      miscompares++; $display("FAIL rd_timeout n=%0d k=%0d want one err ack at 18", ack_k.size(), ack_k.size() ? ack_k[0] : -1);
    end
    vectors++;
    if (ack_d.size() == 0 || ack_d[0] !== {512{1'b1}} || mem_rdata !== {512{1'b1}} || mem_err !== 1'b0) begin
      miscompares++; $display("FAIL rd_timeout_rdata lo=%h err_now=%b want all-ones/0", mem_rdata[63:0], mem_err);
    end
`else
    run_txn(1'b0, 64'h200, '0, 0, 0, 1, 1, 1'b0, -1, 60);
    vectors++;
    if (drv_to != 1 || ack_k.size() != 0) begin
      miscompares++; $display("FAIL no_timeout_waits acks=%0d want 0", ack_k.size());
    end
    vectors++;
    if (bus.rbeat_ready !== 1'b1 || mem_err !== 1'b0) begin
      miscompares++; $display("FAIL no_timeout_state rbeat_ready=%b err=%b want 1/0", bus.rbeat_ready, mem_err);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL tb_time_limit simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_we = 1'b0; mem_wdata = '0;
    bus.cmd_ready = 1'b0; bus.wbeat_ready = 1'b0; bus.rbeat_valid = 1'b0; bus.rbeat_data = '0;
    last_read = '0;
    test_reset();
    test_read();
    test_write_stall();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
